seven_seg_scan_decoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_pattern_decode.sv | 21 ++
 rtl/seven_seg_scan_decoder.sv | 153 +++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low a..g patterns (a = MSB) for the
// hex digits, the blank pattern and the hex digit type.
package seg7_pkg;

  typedef logic [3:0] hex_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-low a..g pattern to its hex value.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_valid,
  output hex_t       o_hex
);

  always_comb begin
    o_valid = 1'b0;
    o_hex   = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == SEG_HEX[i]) begin
        o_valid = 1'b1;
        o_hex   = hex_t'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds the four hex digits shown by a multiplexed LED driver from its
// anode/segment lines, with dwell filtering, frame assembly and error flags.
module seven_seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int MIN_DWELL = 4,
  parameter int TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  input  logic        clr_err,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [3:0]  dp_out,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        overlap_err,
  output logic        code_err,
  output logic        stall
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [DW-1:0] DWELL_ARM = DW'(MIN_DWELL - 1);
  localparam logic [SW-1:0] TIMEOUT_C = SW'(TIMEOUT);

  logic [11:0]     w_in;
  logic [11:0]     r_s;
  logic [DW-1:0]   r_dwell;
  logic [SW-1:0]   r_stall_cnt;
  logic [3:0]      r_seen;
  hex_t [3:0]      r_digit;
  hex_t [3:0]      w_digit_next;
  logic [3:0]      w_seen_next;
  logic [3:0]      w_an_low;
  logic            w_single;
  logic [1:0]      w_idx;
  logic            w_multi;
  logic            w_same;
  logic            w_capture;
  logic            w_dec_valid;
  hex_t            w_dec_hex;
  logic            w_ev_good;
  logic            w_ev_code;
  logic            w_ev_overlap;
  logic            w_frame_done;

  assign w_in = {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};

  // r_s holds the latest sample, so the dwell count includes it; capture fires
  // on the edge where the count would reach MIN_DWELL.
  assign w_same    = (w_in == r_s);
  assign w_capture = w_same && (r_dwell == DWELL_ARM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s     <= {4'hF, SEG_BLANK, 1'b1};
      r_dwell <= '0;
    end else begin
      r_s <= w_in;
      if (!w_same)
        r_dwell <= DW'(1);
      else if (r_dwell != DWELL_MAX)
        r_dwell <= r_dwell + DW'(1);
    end
  end

  seg7_pattern_decode u_decode (
    .i_pattern (r_s[7:1]),
    .o_valid   (w_dec_valid),
    .o_hex     (w_dec_hex)
  );

  assign w_an_low = ~r_s[11:8];

  always_comb begin
    w_single = 1'b1;
    w_idx    = 2'd0;
    case (w_an_low)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_single = 1'b0;
    endcase
  end

  assign w_multi      = (w_an_low != 4'b0000) && !w_single;
  assign w_ev_good    = w_capture && w_single && w_dec_valid;
  assign w_ev_code    = w_capture && w_single && !w_dec_valid;
  assign w_ev_overlap = w_capture && w_multi;

  always_comb begin
    w_digit_next = r_digit;
    w_seen_next  = r_seen;
    if (w_ev_good) begin
      w_digit_next[w_idx] = w_dec_hex;
      w_seen_next[w_idx]  = 1'b1;
    end
  end

  assign w_frame_done = w_ev_good && (w_seen_next == 4'b1111);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit     <= '0;
      r_seen      <= '0;
      dp_out      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      overlap_err <= 1'b0;
      code_err    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_digit     <= w_digit_next;
      r_seen      <= w_frame_done ? 4'b0000 : w_seen_next;
      frame_valid <= w_frame_done;
      if (w_frame_done)
        frame <= w_digit_next;
      if (w_ev_good)
        dp_out[w_idx] <= ~r_s[0];
      // A new event in the clearing cycle keeps the flag set.
      overlap_err <= (overlap_err && !clr_err) || w_ev_overlap;
      code_err    <= (code_err && !clr_err) || w_ev_code;
      if (w_ev_good)
        r_stall_cnt <= '0;
      else if (r_stall_cnt != TIMEOUT_C)
        r_stall_cnt <= r_stall_cnt + SW'(1);
    end
  end

  assign stall  = (r_stall_cnt >= TIMEOUT_C);
  assign digit3 = r_digit[3];
  assign digit2 = r_digit[2];
  assign digit1 = r_digit[1];
  assign digit0 = r_digit[0];

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with MIN_DWELL=4, TIMEOUT=50.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_err;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dpl;
  logic [3:0]  digit3, digit2, digit1, digit0, dp_out;
  logic [15:0] frame;
  logic        frame_valid, overlap_err, code_err, stall;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  int fv_base  = 0;
  logic [6:0] seg_tab [16];

  seven_seg_scan_decoder #(.MIN_DWELL(4), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset),
    .an3(an[3]), .an2(an[2]), .an1(an[1]), .an0(an[0]),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .dp(dpl), .clr_err(clr_err),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .dp_out(dp_out), .frame(frame), .frame_valid(frame_valid),
    .overlap_err(overlap_err), .code_err(code_err), .stall(stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  // frame_valid pulse counter, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (frame_valid) fv_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] get_digit(input int p);
    case (p)
      0: return digit0;
      1: return digit1;
      2: return digit2;
      default: return digit3;
    endcase
  endfunction

  task automatic drive_blank();
    an  = 4'hF;
    seg = 7'h7F;
    dpl = 1'b1;
  endtask

  // Drives a single-anode digit; checks it is not taken after 3 samples and
  // is taken after the 4th. Returns one negedge after the capture edge.
  task automatic scan_digit(input int pos, input logic [3:0] val, input logic dp_on,
                            input logic [3:0] old_val);
    logic [3:0] onehot;
    onehot = 4'b0001 << pos;
    an  = ~onehot;
    seg = seg_tab[val];
    dpl = ~dp_on;
    repeat (3) @(negedge clk);
    check_eq($sformatf("d%0d_early", pos), get_digit(pos), old_val);
    @(negedge clk);
    check_eq($sformatf("d%0d_upd", pos), get_digit(pos), val);
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    reset   = 1'b1;
    clr_err = 1'b0;
    drive_blank();
    repeat (3) @(negedge clk);
    check_eq("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check_eq("rst_frame", frame, 16'h0000);
    check_eq("rst_flags", {frame_valid, overlap_err, code_err, stall, dp_out}, 8'h00);
    reset = 1'b0;

    // scan 1,2,3,4 on an0..an3, 8 cycles each, dp lit on digit 2
    for (int i = 0; i < 4; i++) begin
      scan_digit(i, 4'(i + 1), (i == 2), 4'h0);
      check_eq($sformatf("fv_pulse%0d", i), frame_valid, (i == 3));
      @(negedge clk);
      check_eq($sformatf("fv_low%0d", i), frame_valid, 1'b0);
      repeat (3) @(negedge clk);
    end
    check_eq("frame_4321", frame, 16'h4321);
    check_eq("dp_out_1", dp_out, 4'b0100);
    check_eq("fv_count_1", fv_cnt, 1);

    // glitch: digit 5 held 3 samples only
    an  = 4'b1110;
    seg = seg_tab[5];
    repeat (3) @(negedge clk);
    drive_blank();
    repeat (6) @(negedge clk);
    check_eq("glitch_d0", digit0, 4'h1);
    check_eq("glitch_err", {overlap_err, code_err}, 2'b00);

    // overlap an1+an2 with pattern 8
    an  = 4'b1001;
    seg = seg_tab[8];
    repeat (6) @(negedge clk);
    check_eq("ovl_set", overlap_err, 1'b1);
    check_eq("ovl_digits", {digit2, digit1}, 8'h32);
    check_eq("ovl_code", code_err, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("ovl_clr", overlap_err, 1'b0);
    drive_blank();
    repeat (2) @(negedge clk);

    // clear coinciding with a new overlap event: flag must stay set
    an  = 4'b0011;
    seg = seg_tab[8];
    repeat (3) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("ovl_set_wins", overlap_err, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("ovl_clr2", overlap_err, 1'b0);
    drive_blank();
    repeat (2) @(negedge clk);

    // undecodable pattern on an0
    an  = 4'b1110;
    seg = 7'b1111110;
    repeat (6) @(negedge clk);
    check_eq("code_set", code_err, 1'b1);
    check_eq("code_d0", digit0, 4'h1);
    check_eq("code_no_fv", fv_cnt, 1);
    scan_digit(1, 4'h7, 1'b0, 4'h2);
    repeat (4) @(negedge clk);
    scan_digit(2, 4'h8, 1'b0, 4'h3);
    repeat (4) @(negedge clk);
    scan_digit(3, 4'h9, 1'b0, 4'h4);
    repeat (4) @(negedge clk);
    check_eq("code_seen_kept", fv_cnt, 1);
    scan_digit(0, 4'hA, 1'b0, 4'h1);
    check_eq("fv_pulse_2", frame_valid, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("frame_987a", frame, 16'h987A);
    check_eq("fv_count_2", fv_cnt, 2);
    check_eq("dp_out_2", dp_out, 4'b0000);

    // stall: good capture, then blank for TIMEOUT cycles
    drive_blank();
    repeat (2) @(negedge clk);
    scan_digit(0, 4'h0, 1'b0, 4'hA);
    drive_blank();
    repeat (49) @(negedge clk);
    check_eq("stall_49", stall, 1'b0);
    @(negedge clk);
    check_eq("stall_50", stall, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("stall_sat", stall, 1'b1);
    an  = 4'b1110;
    seg = seg_tab[3];
    repeat (3) @(negedge clk);
    check_eq("stall_hold", stall, 1'b1);
    @(negedge clk);
    check_eq("stall_fall", stall, 1'b0);
    check_eq("stall_d0", digit0, 4'h3);
    repeat (4) @(negedge clk);

    // reset mid-frame after three digits captured
    scan_digit(1, 4'h2, 1'b0, 4'h7);
    repeat (4) @(negedge clk);
    scan_digit(2, 4'h3, 1'b1, 4'h8);
    repeat (4) @(negedge clk);
    check_eq("pre_rst_dp", dp_out, 4'b0100);
    reset = 1'b1;
    drive_blank();
    repeat (2) @(negedge clk);
    check_eq("rst2_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check_eq("rst2_flags", {frame, dp_out, code_err, stall}, 22'h0);
    reset   = 1'b0;
    fv_base = fv_cnt;
    scan_digit(3, 4'h5, 1'b0, 4'h0);
    repeat (4) @(negedge clk);
    scan_digit(0, 4'h6, 1'b0, 4'h0);
    repeat (4) @(negedge clk);
    check_eq("rst_no_frame", fv_cnt, fv_base);
    scan_digit(1, 4'h7, 1'b0, 4'h0);
    repeat (4) @(negedge clk);
    scan_digit(2, 4'h8, 1'b0, 4'h0);
    check_eq("fv_pulse_3", frame_valid, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("frame_5876", frame, 16'h5876);
    check_eq("fv_count_3", fv_cnt, fv_base + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
